// File: rtl/pipe_pkg.sv
// Shared types for the hazard-tracking pipeline registers.
package pipe_pkg;

  localparam int DEFAULT_REG_W = 4;

  // Hazard-relevant fields of one in-flight instruction
  typedef struct packed {
    logic [DEFAULT_REG_W-1:0] ra1;
    logic [DEFAULT_REG_W-1:0] ra2;
    logic [DEFAULT_REG_W-1:0] wa3;
    logic                     regwrite;
    logic                     memtoreg;
    logic                     branch;
    logic                     pcsrc;
    logic                     valid;
  } hz_fields_t;

  localparam hz_fields_t HZ_BUBBLE = '0;

endpackage

// File: rtl/hz_stage_reg.sv
// One pipeline register of hazard fields with flush-to-bubble and enable.
module hz_stage_reg
  import pipe_pkg::*;
#(
  parameter hz_fields_t RESET_VAL = HZ_BUBBLE
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       flush,
  input  hz_fields_t d,
  output hz_fields_t q
);

  // Reset and flush both load a bubble; otherwise capture when enabled
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      q <= RESET_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/hazard_pipe_tracker.sv
// Producer side of the hazard interface: carries register numbers and
// hazard controls from Decode through Writeback and counts stalls,
// flushes and retirements.
module hazard_pipe_tracker
  import pipe_pkg::*;
#(
  parameter int REG_W = DEFAULT_REG_W,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] RA1D,
  input  logic [REG_W-1:0] RA2D,
  input  logic [REG_W-1:0] WA3D,
  input  logic             RegWriteD,
  input  logic             MemtoRegD,
  input  logic             BranchD,
  input  logic             PCSrcDecD,
  input  logic             CondExE,
  input  logic             StallD,
  input  logic             FlushD,
  input  logic             FlushE,
  output logic [REG_W-1:0] RA1E,
  output logic [REG_W-1:0] RA2E,
  output logic [REG_W-1:0] WA3E,
  output logic [REG_W-1:0] WA3M,
  output logic [REG_W-1:0] WA3W,
  output logic             RegWriteM,
  output logic             RegWriteW,
  output logic             MemtoRegE,
  output logic             PCSrcD,
  output logic             PCSrcE,
  output logic             PCSrcM,
  output logic             PCSrcW,
  output logic             BranchTakenE,
  output logic             ValidE,
  output logic             ValidW,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt,
  output logic [CNT_W-1:0] RetireCnt
);

  logic       valid_d;
  hz_fields_t e_in, e_q;
  hz_fields_t m_in, m_q;
  hz_fields_t w_q;
  logic       unused_fields;

  // Decode validity: flush empties D, stall holds it, otherwise D fills
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_d <= 1'b0;
    end else if (FlushD) begin
      valid_d <= 1'b0;
    end else if (!StallD) begin
      valid_d <= 1'b1;
    end
  end

  assign PCSrcD = PCSrcDecD & valid_d;

  // Register numbers pass through; control bits only count for a real instruction
  always_comb begin
    e_in          = HZ_BUBBLE;
    e_in.ra1      = RA1D;
    e_in.ra2      = RA2D;
    e_in.wa3      = WA3D;
    e_in.regwrite = RegWriteD & valid_d;
    e_in.memtoreg = MemtoRegD & valid_d;
    e_in.branch   = BranchD & valid_d;
    e_in.pcsrc    = PCSrcDecD & valid_d;
    e_in.valid    = valid_d;
  end

  hz_stage_reg u_reg_e (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (1'b1),
    .flush (FlushE),
    .d     (e_in),
    .q     (e_q)
  );

  // A failed condition squashes the register write and PC write in E
  always_comb begin
    m_in          = e_q;
    m_in.regwrite = e_q.regwrite & CondExE;
    m_in.pcsrc    = e_q.pcsrc & CondExE;
  end

  hz_stage_reg u_reg_m (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (1'b1),
    .flush (1'b0),
    .d     (m_in),
    .q     (m_q)
  );

  hz_stage_reg u_reg_w (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (1'b1),
    .flush (1'b0),
    .d     (m_q),
    .q     (w_q)
  );

  assign RA1E         = e_q.ra1;
  assign RA2E         = e_q.ra2;
  assign WA3E         = e_q.wa3;
  assign MemtoRegE    = e_q.memtoreg;
  assign PCSrcE       = e_q.pcsrc;
  assign ValidE       = e_q.valid;
  assign BranchTakenE = e_q.branch & CondExE & e_q.valid;
  assign WA3M         = m_q.wa3;
  assign RegWriteM    = m_q.regwrite;
  assign PCSrcM       = m_q.pcsrc;
  assign WA3W         = w_q.wa3;
  assign RegWriteW    = w_q.regwrite;
  assign PCSrcW       = w_q.pcsrc;
  assign ValidW       = w_q.valid;

  // Fields carried for uniformity but not consumed downstream of E
  assign unused_fields = ^{m_q.ra1, m_q.ra2, m_q.memtoreg, m_q.branch, m_q.valid,
                           w_q.ra1, w_q.ra2, w_q.memtoreg, w_q.branch};

  // Saturating performance counters; they stop at all-ones instead of wrapping
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      StallCnt  <= '0;
      FlushCnt  <= '0;
      RetireCnt <= '0;
    end else begin
      if (StallD && (StallCnt != {CNT_W{1'b1}})) begin
        StallCnt <= StallCnt + CNT_W'(1);
      end
      if ((FlushD || FlushE) && (FlushCnt != {CNT_W{1'b1}})) begin
        FlushCnt <= FlushCnt + CNT_W'(1);
      end
      if (w_q.valid && (RetireCnt != {CNT_W{1'b1}})) begin
        RetireCnt <= RetireCnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hazard_pipe_tracker.sv
// Directed self-checking bench for hazard_pipe_tracker, plus a narrow
// counter instance sharing the same inputs to exercise saturation.
module tb_hazard_pipe_tracker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] RA1D = '0, RA2D = '0, WA3D = '0;
  logic       RegWriteD = 0, MemtoRegD = 0, BranchD = 0, PCSrcDecD = 0;
  logic       CondExE = 0, StallD = 0, FlushD = 0, FlushE = 0;

  logic [3:0]  RA1E, RA2E, WA3E, WA3M, WA3W;
  logic        RegWriteM, RegWriteW, MemtoRegE;
  logic        PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE, ValidE, ValidW;
  logic [15:0] StallCnt, FlushCnt, RetireCnt;

  logic [3:0] s_ra1e, s_ra2e, s_wa3e, s_wa3m, s_wa3w;
  logic       s_rwm, s_rww, s_m2re, s_pcd, s_pce, s_pcm, s_pcw, s_bte, s_ve, s_vw;
  logic [2:0] s_stall, s_flush, s_retire;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  hazard_pipe_tracker dut (
    .clk(clk), .rst_n(rst_n),
    .RA1D(RA1D), .RA2D(RA2D), .WA3D(WA3D),
    .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .BranchD(BranchD), .PCSrcDecD(PCSrcDecD),
    .CondExE(CondExE), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .RA1E(RA1E), .RA2E(RA2E), .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemtoRegE(MemtoRegE),
    .PCSrcD(PCSrcD), .PCSrcE(PCSrcE), .PCSrcM(PCSrcM), .PCSrcW(PCSrcW),
    .BranchTakenE(BranchTakenE), .ValidE(ValidE), .ValidW(ValidW),
    .StallCnt(StallCnt), .FlushCnt(FlushCnt), .RetireCnt(RetireCnt)
  );

  hazard_pipe_tracker #(.REG_W(4), .CNT_W(3)) dut_sat (
    .clk(clk), .rst_n(rst_n),
    .RA1D(RA1D), .RA2D(RA2D), .WA3D(WA3D),
    .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .BranchD(BranchD), .PCSrcDecD(PCSrcDecD),
    .CondExE(CondExE), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .RA1E(s_ra1e), .RA2E(s_ra2e), .WA3E(s_wa3e), .WA3M(s_wa3m), .WA3W(s_wa3w),
    .RegWriteM(s_rwm), .RegWriteW(s_rww), .MemtoRegE(s_m2re),
    .PCSrcD(s_pcd), .PCSrcE(s_pce), .PCSrcM(s_pcm), .PCSrcW(s_pcw),
    .BranchTakenE(s_bte), .ValidE(s_ve), .ValidW(s_vw),
    .StallCnt(s_stall), .FlushCnt(s_flush), .RetireCnt(s_retire)
  );

  // Advance one cycle and settle just after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic set_idle();
    RA1D = '0; RA2D = '0; WA3D = '0;
    RegWriteD = 0; MemtoRegD = 0; BranchD = 0; PCSrcDecD = 0;
    CondExE = 0; StallD = 0; FlushD = 0; FlushE = 0;
  endtask

  // Reset, then one edge so Decode holds a valid slot; counters are zero
  task automatic do_reset();
    set_idle();
    rst_n = 0;
    tick();
    rst_n = 1;
    tick();
  endtask

  initial begin
    // Reset state, with PCSrcDecD high to show D is not yet valid
    set_idle();
    PCSrcDecD = 1;
    rst_n = 0;
    tick();
    tick();
    check_output("rst_WA3E", WA3E, 0);
    check_output("rst_RegWriteW", RegWriteW, 0);
    check_output("rst_ValidE", ValidE, 0);
    check_output("rst_ValidW", ValidW, 0);
    check_output("rst_PCSrcD", PCSrcD, 0);
    check_output("rst_StallCnt", StallCnt, 0);
    check_output("rst_RetireCnt", RetireCnt, 0);
    rst_n = 1;
    tick();
    check_output("validd_PCSrcD", PCSrcD, 1);
    check_output("first_E_bubble", ValidE, 0);

    // Single instruction through all stages
    do_reset();
    WA3D = 5; RegWriteD = 1; RA1D = 3; CondExE = 1;
    tick();
    check_output("lat1_WA3E", WA3E, 5);
    check_output("lat1_RA1E", RA1E, 3);
    check_output("lat1_ValidE", ValidE, 1);
    WA3D = 0; RegWriteD = 0; RA1D = 0;
    tick();
    check_output("lat2_WA3M", WA3M, 5);
    check_output("lat2_RegWriteM", RegWriteM, 1);
    tick();
    check_output("lat3_WA3W", WA3W, 5);
    check_output("lat3_RegWriteW", RegWriteW, 1);
    check_output("lat3_RetireCnt", RetireCnt, 0);
    tick();
    check_output("lat4_RetireCnt", RetireCnt, 1);

    // Load-use stall: bubble into E while D holds the dependent instruction
    do_reset();
    MemtoRegD = 1; WA3D = 5; RegWriteD = 1;
    tick();
    check_output("lu_MemtoRegE", MemtoRegE, 1);
    MemtoRegD = 0; WA3D = 6; RA1D = 5; StallD = 1; FlushE = 1;
    tick();
    check_output("lu_MemtoRegE_bubble", MemtoRegE, 0);
    check_output("lu_ValidE_bubble", ValidE, 0);
    check_output("lu_RA1E_bubble", RA1E, 0);
    check_output("lu_StallCnt", StallCnt, 1);
    check_output("lu_FlushCnt", FlushCnt, 1);
    check_output("lu_WA3M", WA3M, 5);
    StallD = 0; FlushE = 0;
    tick();
    check_output("lu_release_RA1E", RA1E, 5);
    check_output("lu_release_ValidE", ValidE, 1);
    check_output("lu_release_StallCnt", StallCnt, 1);

    // Conditional fail squashes write and PC update but stays valid
    do_reset();
    RegWriteD = 1; BranchD = 1; PCSrcDecD = 1; WA3D = 15;
    #1;
    check_output("cf_PCSrcD", PCSrcD, 1);
    tick();
    set_idle();
    #1;
    check_output("cf_BranchTakenE", BranchTakenE, 0);
    check_output("cf_PCSrcE", PCSrcE, 1);
    tick();
    check_output("cf_RegWriteM", RegWriteM, 0);
    check_output("cf_PCSrcM", PCSrcM, 0);
    check_output("cf_WA3M", WA3M, 15);
    tick();
    check_output("cf_ValidW", ValidW, 1);
    check_output("cf_RegWriteW", RegWriteW, 0);
    check_output("cf_PCSrcW", PCSrcW, 0);

    // Taken branch followed by a double flush
    do_reset();
    BranchD = 1; PCSrcDecD = 1;
    tick();
    set_idle();
    CondExE = 1;
    #1;
    check_output("tb_BranchTakenE", BranchTakenE, 1);
    FlushD = 1; FlushE = 1; PCSrcDecD = 1;
    tick();
    check_output("tb_PCSrcD_flushed", PCSrcD, 0);
    check_output("tb_ValidE_flushed", ValidE, 0);
    check_output("tb_PCSrcM", PCSrcM, 1);
    check_output("tb_FlushCnt", FlushCnt, 1);
    FlushD = 0; FlushE = 0;
    tick();
    check_output("tb_PCSrcD_refill", PCSrcD, 1);
    check_output("tb_ValidE_after", ValidE, 0);
    check_output("tb_FlushCnt_hold", FlushCnt, 1);
    check_output("tb_PCSrcW", PCSrcW, 1);

    // Flush wins over stall in D; a stall alone then holds the empty slot
    do_reset();
    PCSrcDecD = 1; StallD = 1; FlushD = 1;
    tick();
    check_output("sf_PCSrcD", PCSrcD, 0);
    check_output("sf_StallCnt", StallCnt, 1);
    check_output("sf_FlushCnt", FlushCnt, 1);
    FlushD = 0;
    tick();
    check_output("sf_hold_PCSrcD", PCSrcD, 0);
    check_output("sf_hold_StallCnt", StallCnt, 2);
    StallD = 0;
    tick();
    check_output("sf_release_PCSrcD", PCSrcD, 1);

    // Reset in the middle of a full pipeline
    do_reset();
    RegWriteD = 1; WA3D = 9; CondExE = 1; StallD = 1;
    tick();
    StallD = 0;
    tick();
    tick();
    tick();
    check_output("mr_pre_WA3W", WA3W, 9);
    check_output("mr_pre_RetireCnt", RetireCnt, 1);
    check_output("mr_pre_StallCnt", StallCnt, 1);
    rst_n = 0;
    tick();
    check_output("mr_WA3E", WA3E, 0);
    check_output("mr_WA3M", WA3M, 0);
    check_output("mr_WA3W", WA3W, 0);
    check_output("mr_RegWriteM", RegWriteM, 0);
    check_output("mr_RegWriteW", RegWriteW, 0);
    check_output("mr_ValidE", ValidE, 0);
    check_output("mr_ValidW", ValidW, 0);
    check_output("mr_RetireCnt", RetireCnt, 0);
    check_output("mr_StallCnt", StallCnt, 0);
    rst_n = 1;
    set_idle();
    tick();
    check_output("mr_empty_ValidE", ValidE, 0);

    // Counter saturation on the 3-bit instance
    do_reset();
    StallD = 1;
    for (int i = 0; i < 7; i++) tick();
    check_output("sat_at7", s_stall, 7);
    for (int i = 0; i < 3; i++) tick();
    check_output("sat_hold", s_stall, 7);
    check_output("sat_wide_ref", StallCnt, 10);
    StallD = 0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
